// File: rtl/zxuno_spi_pkg.sv
// Purpose: shared types and constants for the two-requester SPI bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zxuno_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic TARGET_FLASH  = 1'b0;
  localparam logic TARGET_SD     = 1'b1;
  localparam logic SPI_IDLE_MOSI = 1'b1;

  // Chip-select pair {sd_cs_n, flash_cs_n} that selects exactly one target.
  function automatic logic [1:0] cs_n_for(input logic target);
    return {target != TARGET_SD, target != TARGET_FLASH};
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Purpose: SPI mode-0 byte engine, MSB first, SCK half-period CLKDIV clk cycles.
// Latency: done pulses 16*CLKDIV cycles after the cycle in which start is high.
// Backpressure: start is accepted only while idle; starts during a byte are dropped.
// Ports: start/tx load a byte, miso is sampled on SCK rise, sck/mosi drive the pins,
//        busy is high for the whole byte, done pulses with rx valid on the final SCK fall.
module spi_byte_shifter
  import zxuno_spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
  // The start cycle itself counts as the first low-phase cycle, so the
  // divider resumes at 1; this keeps back-to-back bytes at exactly CLKDIV
  // low cycles between the last fall and the next rise.
  localparam logic [DW-1:0] DIV_FIRST = (CLKDIV > 1) ? DW'(1) : DW'(0);

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          miso_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck      <= 1'b0;
      mosi     <= SPI_IDLE_MOSI;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx       <= 8'hFF;
      shreg    <= 8'hFF;
      miso_bit <= 1'b1;
      bit_cnt  <= '0;
      div_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          shreg   <= tx;
          mosi    <= tx[7];
          bit_cnt <= '0;
          div_cnt <= DIV_FIRST;
          // With a one-cycle half-period the low phase is already over.
          if (CLKDIV == 1) begin
            sck      <= 1'b1;
            miso_bit <= miso;
          end
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!sck) begin
          sck      <= 1'b1;
          miso_bit <= miso;
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 3'd7) begin
            busy <= 1'b0;
            done <= 1'b1;
            rx   <= {shreg[6:0], miso_bit};
            mosi <= SPI_IDLE_MOSI;
          end else begin
            // Received bits enter at the bottom as transmit bits leave the top.
            shreg   <= {shreg[6:0], miso_bit};
            mosi    <= shreg[6];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Purpose: shares one SPI byte engine between the flash loader (0) and the Z80 port (1).
// Latency: grant 1 cycle after request seen in IDLE; done 16*CLKDIV cycles after start.
// Backpressure: bus held for the whole request; starts ignored unless owner and engine idle.
// Ports: reqN/selN/startN/txN from each requester, gntN/doneN/rxN back to it;
//        flash_cs_n/sd_cs_n/spi_clk/spi_mosi/flash_miso/sd_miso to the pins; spi_busy to the LED.
module spi_bus_arbiter
  import zxuno_spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       sel0,
  input  logic       start0,
  input  logic [7:0] tx0,
  output logic       gnt0,
  output logic       done0,
  output logic [7:0] rx0,
  input  logic       req1,
  input  logic       sel1,
  input  logic       start1,
  input  logic [7:0] tx1,
  output logic       gnt1,
  output logic       done1,
  output logic [7:0] rx1,
  output logic       flash_cs_n,
  output logic       sd_cs_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       flash_miso,
  input  logic       sd_miso,
  output logic       spi_busy
);

  arb_state_t state;
  logic       last_gnt;
  logic       target;
  logic       eng_start;
  logic       eng_busy;
  logic       eng_done;
  logic       eng_miso;
  logic [7:0] eng_tx;
  logic [7:0] eng_rx;
  logic [7:0] rx0_q;
  logic [7:0] rx1_q;

  // Starts are taken only in the owning states; DRAIN is a pure release path.
  assign eng_start = !eng_busy && (((state == OWN0) && start0) || ((state == OWN1) && start1));
  assign eng_tx    = (state == OWN1) ? tx1 : tx0;
  assign eng_miso  = (target == TARGET_SD) ? sd_miso : flash_miso;

  // The owner's grant is still high on the done cycle, even when draining.
  assign done0 = eng_done & gnt0;
  assign done1 = eng_done & gnt1;
  assign rx0   = done0 ? eng_rx : rx0_q;
  assign rx1   = done1 ? eng_rx : rx1_q;

  spi_byte_shifter #(.CLKDIV(CLKDIV)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (eng_start),
    .tx    (eng_tx),
    .miso  (eng_miso),
    .sck   (spi_clk),
    .mosi  (spi_mosi),
    .busy  (eng_busy),
    .done  (eng_done),
    .rx    (eng_rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      flash_cs_n <= 1'b1;
      sd_cs_n    <= 1'b1;
      spi_busy   <= 1'b0;
      last_gnt   <= 1'b1;
      target     <= TARGET_FLASH;
      rx0_q      <= 8'hFF;
      rx1_q      <= 8'hFF;
    end else begin
      if (done0) rx0_q <= eng_rx;
      if (done1) rx1_q <= eng_rx;
      case (state)
        IDLE: begin
          // On a tie the requester not granted last wins.
          if (req0 && (!req1 || last_gnt)) begin
            state                 <= OWN0;
            gnt0                  <= 1'b1;
            last_gnt              <= 1'b0;
            target                <= sel0;
            {sd_cs_n, flash_cs_n} <= cs_n_for(sel0);
            spi_busy              <= 1'b1;
          end else if (req1) begin
            state                 <= OWN1;
            gnt1                  <= 1'b1;
            last_gnt              <= 1'b1;
            target                <= sel1;
            {sd_cs_n, flash_cs_n} <= cs_n_for(sel1);
            spi_busy              <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if ((state == OWN0) ? !req0 : !req1) begin
            // A start accepted on the release cycle still has to finish.
            if (eng_busy || eng_start) begin
              state <= DRAIN;
            end else begin
              state      <= IDLE;
              gnt0       <= 1'b0;
              gnt1       <= 1'b0;
              flash_cs_n <= 1'b1;
              sd_cs_n    <= 1'b1;
              spi_busy   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (eng_done) begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            flash_cs_n <= 1'b1;
            sd_cs_n    <= 1'b1;
            spi_busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Purpose: self-checking bench for spi_bus_arbiter with an SPI slave model and a done scoreboard.
// Latency: expects done 16*CLKDIV cycles after the start cycle, grant 1 cycle after request.
// Backpressure: ignored starts must produce no done; unexpected dones are flagged.
module tb_spi_bus_arbiter;

  localparam int CLKDIV   = 2;
  localparam int BYTE_CYC = 16 * CLKDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0, sel0, start0, req1, sel1, start1;
  logic [7:0] tx0, tx1;
  logic       gnt0, done0, gnt1, done1;
  logic [7:0] rx0, rx1;
  logic       flash_cs_n, sd_cs_n, spi_clk, spi_mosi, flash_miso, sd_miso, spi_busy;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .sel0(sel0), .start0(start0), .tx0(tx0), .gnt0(gnt0), .done0(done0), .rx0(rx0),
    .req1(req1), .sel1(sel1), .start1(start1), .tx1(tx1), .gnt1(gnt1), .done1(done1), .rx1(rx1),
    .flash_cs_n(flash_cs_n), .sd_cs_n(sd_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .flash_miso(flash_miso), .sd_miso(sd_miso), .spi_busy(spi_busy)
  );

  typedef struct {
    int         who;
    logic [7:0] rx;
    logic [7:0] mosi;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rise_total = 0;
  int         rise_base = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] fl_byte = 8'hFF;
  logic [7:0] sd_byte = 8'hFF;
  logic [7:0] fl_sh = 8'hFF;
  logic [7:0] sd_sh = 8'hFF;
  logic       slv_load = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Slave model: both targets shift out their byte on SCK falls; MOSI captured on rises.
  always @(posedge spi_clk) begin
    rise_total = rise_total + 1;
    mosi_cap   = {mosi_cap[6:0], spi_mosi};
  end

  always @(negedge spi_clk or posedge slv_load) begin
    if (slv_load) begin
      fl_sh = fl_byte;
      sd_sh = sd_byte;
    end else begin
      fl_sh = {fl_sh[6:0], 1'b1};
      sd_sh = {sd_sh[6:0], 1'b1};
    end
  end

  assign flash_miso = fl_sh[7];
  assign sd_miso    = sd_sh[7];

  // Monitor: every done pulse pops one expected byte.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      rise_base = rise_total;
    end else if (done0 || done1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'({done1, done0}), 0);
      end else begin
        e = sb.pop_front();
        chk("done_who", 32'({done1, done0}), (e.who == 1) ? 2 : 1);
        chk("rx_byte", 32'((e.who == 1) ? rx1 : rx0), 32'(e.rx));
        chk("mosi_bits", 32'(mosi_cap), 32'(e.mosi));
        chk("sck_rises", 32'(rise_total - rise_base), 8);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
      rise_base = rise_total;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a start expected to be accepted; tgt picks which slave byte comes back.
  task automatic start_byte(input int who, input logic [7:0] tx, input logic [7:0] fl,
                            input logic [7:0] sd, input logic tgt);
    exp_t e;
    fl_byte  = fl;
    sd_byte  = sd;
    slv_load = 1'b1;
    #1 slv_load = 1'b0;
    e.who  = who;
    e.rx   = tgt ? sd : fl;
    e.mosi = tx;
    e.cyc  = cyc + BYTE_CYC;
    sb.push_back(e);
    if (who == 0) begin tx0 = tx; start0 = 1'b1; end
    else          begin tx1 = tx; start1 = 1'b1; end
    step(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin step(1); n++; end
    chk("scoreboard_drained", 32'(sb.size()), 0);
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    while (done0 !== 1'b1 && n < budget) begin step(1); n++; end
    chk("done0_seen", 32'(done0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    {req0, sel0, start0, req1, sel1, start1} = '0;
    tx0 = 8'h00;
    tx1 = 8'h00;
    step(3);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_flash_cs_n", 32'(flash_cs_n), 1);
    chk("rst_sd_cs_n", 32'(sd_cs_n), 1);
    chk("rst_spi_clk", 32'(spi_clk), 0);
    chk("rst_spi_mosi", 32'(spi_mosi), 1);
    chk("rst_spi_busy", 32'(spi_busy), 0);
    chk("rst_rx0", 32'(rx0), 'hFF);
    chk("rst_rx1", 32'(rx1), 'hFF);
    chk("rst_done", 32'({done1, done0}), 0);
    rst = 1'b0;
    step(1);

    // Ties: requester 0 wins first after reset, then alternation.
    sel0 = 1'b0; sel1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    chk("tie1_gnt0", 32'(gnt0), 1);
    chk("tie1_gnt1", 32'(gnt1), 0);
    chk("tie1_flash_cs_n", 32'(flash_cs_n), 0);
    chk("tie1_sd_cs_n", 32'(sd_cs_n), 1);
    chk("tie1_busy", 32'(spi_busy), 1);
    req0 = 1'b0;
    step(1);
    chk("gap_gnt", 32'({gnt1, gnt0}), 0);
    chk("gap_cs", 32'({sd_cs_n, flash_cs_n}), 3);
    step(1);
    chk("handover_gnt1", 32'(gnt1), 1);
    chk("handover_sd_cs_n", 32'(sd_cs_n), 0);
    req1 = 1'b0;
    step(1);
    chk("rel1_gnt1", 32'(gnt1), 0);
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    chk("tie2_gnt", 32'({gnt1, gnt0}), 1);
    req0 = 1'b0; req1 = 1'b0;
    step(1);
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    chk("tie3_gnt", 32'({gnt1, gnt0}), 2);
    req0 = 1'b0; req1 = 1'b0;
    step(2);

    // Single requester 1 read from SD; sel change while owned is ignored.
    req1 = 1'b1; sel1 = 1'b1;
    chk("t1_gnt1_pre", 32'(gnt1), 0);
    step(1);
    chk("t1_gnt1", 32'(gnt1), 1);
    chk("t1_cs", 32'({sd_cs_n, flash_cs_n}), 1);
    sel1 = 1'b0;
    start_byte(1, 8'hA5, 8'hC3, 8'h3C, 1'b1);
    wait_empty(40);
    chk("t1_sd_cs_n_held", 32'(sd_cs_n), 0);
    chk("t1_rx1_hold", 32'(rx1), 'h3C);
    chk("t1_rx0_untouched", 32'(rx0), 'hFF);
    req1 = 1'b0;
    step(1);
    chk("t1_rel_gnt1", 32'(gnt1), 0);
    chk("t1_rel_sd_cs_n", 32'(sd_cs_n), 1);
    sel1 = 1'b1;

    // Release mid-byte: byte completes, then bus releases the cycle after done.
    req0 = 1'b1; sel0 = 1'b0;
    step(1);
    start_byte(0, 8'h3C, 8'h96, 8'h69, 1'b0);
    step(4);
    req0 = 1'b0;
    wait_done0(40);
    chk("t3_gnt0_at_done", 32'(gnt0), 1);
    chk("t3_flash_cs_n_at_done", 32'(flash_cs_n), 0);
    step(1);
    chk("t3_gnt0_after", 32'(gnt0), 0);
    chk("t3_flash_cs_n_after", 32'(flash_cs_n), 1);
    chk("t3_busy_after", 32'(spi_busy), 0);
    chk("t3_rx1_untouched", 32'(rx1), 'h3C);

    // Ignored starts: non-owner start, and owner start while busy.
    req0 = 1'b1; sel0 = 1'b1;
    step(1);
    chk("t4_cs", 32'({sd_cs_n, flash_cs_n}), 1);
    tx1 = 8'h00; start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    start_byte(0, 8'h5A, 8'h0F, 8'hE7, 1'b1);
    step(3);
    tx0 = 8'hFF; start0 = 1'b1; tx1 = 8'h00; start1 = 1'b1;
    step(1);
    start0 = 1'b0; start1 = 1'b0;
    wait_empty(40);
    step(40);
    chk("t4_rx0", 32'(rx0), 'hE7);
    req0 = 1'b0;
    step(2);

    // Back-to-back bytes: SCK low for exactly CLKDIV cycles between them.
    req0 = 1'b1; sel0 = 1'b0;
    step(1);
    start_byte(0, 8'h81, 8'h18, 8'h00, 1'b0);
    wait_done0(40);
    chk("t6_sck_low_d0", 32'(spi_clk), 0);
    start_byte(0, 8'h7E, 8'hE1, 8'h11, 1'b0);
    chk("t6_sck_low_d1", 32'(spi_clk), 0);
    chk("t6_cs_held", 32'(flash_cs_n), 0);
    step(1);
    chk("t6_sck_rise_d2", 32'(spi_clk), 1);
    wait_empty(40);
    chk("t6_cs_held_end", 32'(flash_cs_n), 0);
    req0 = 1'b0;
    step(2);

    // Reset mid-transfer: abandon byte, then a clean grant and full byte.
    req0 = 1'b1; sel0 = 1'b0;
    step(1);
    start_byte(0, 8'hC3, 8'hA5, 8'h00, 1'b0);
    step(12);
    rst = 1'b1;
    #1;
    chk("t5_flash_cs_n", 32'(flash_cs_n), 1);
    chk("t5_sd_cs_n", 32'(sd_cs_n), 1);
    chk("t5_spi_clk", 32'(spi_clk), 0);
    chk("t5_spi_mosi", 32'(spi_mosi), 1);
    chk("t5_gnt0", 32'(gnt0), 0);
    chk("t5_done", 32'({done1, done0}), 0);
    chk("t5_rx0", 32'(rx0), 'hFF);
    step(2);
    rst = 1'b0;
    chk("t5_gnt0_pre", 32'(gnt0), 0);
    step(1);
    chk("t5_gnt0_regrant", 32'(gnt0), 1);
    chk("t5_flash_cs_n_regrant", 32'(flash_cs_n), 0);
    start_byte(0, 8'hC3, 8'hA5, 8'h00, 1'b0);
    wait_empty(40);
    chk("t5_rx0_final", 32'(rx0), 'hA5);
    req0 = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one byte-wide SPI mode-0 shift engine between two requesters: requester 0 is the boot/ROM flash loader, requester 1 is the Z80-side SPI port.
- Each requester locks the bus for a whole transaction, selects a target (SPI flash or SD card) and issues byte transfers.
- Sits between the core's SPI users and the flash_*/sd_* pins; spi_busy drives the SPI activity test LED.

Parameters:
CLKDIV, 2, SCK half-period in clk cycles (>=1); 2 gives 7 MHz SCK at 28 MHz sysclk.

Ports:
- clk  in  1  system clock (sysclk domain)
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 bus request; level, held for the whole transaction
- sel0  in  1  requester 0 target: 0 = flash, 1 = SD
- start0  in  1  requester 0 one-cycle byte-start strobe
- tx0  in  8  requester 0 byte to send
- gnt0  out  1  requester 0 owns the bus
- done0  out  1  one-cycle pulse: requester 0 byte complete
- rx0  out  8  requester 0 last received byte
- req1, sel1, start1, tx1, gnt1, done1, rx1  same as above, for requester 1
- flash_cs_n  out  1  flash chip select, active-low
- sd_cs_n  out  1  SD chip select, active-low
- spi_clk  out  1  shared SCK
- spi_mosi  out  1  shared MOSI
- flash_miso  in  1  flash data out
- sd_miso  in  1  SD data out
- spi_busy  out  1  high while either chip select is asserted

Behaviour:
- Reset (async, immediate):
  - gnt0 = gnt1 = 0; done0 = done1 = 0; rx0 = rx1 = 8'hFF.
  - flash_cs_n = sd_cs_n = 1; spi_clk = 0; spi_mosi = 1; spi_busy = 0.
  - last-grant flag = 1; engine idle.
  - A byte in flight is abandoned; no done pulse is issued.
- Arbiter FSM states: IDLE, OWN0, OWN1, DRAIN.
  - IDLE: if only reqN is high, go to OWNN on the next edge. If both are high, grant the requester that was not granted last; after reset that is requester 0.
  - Grant latency: gntN rises exactly 1 cycle after reqN is first sampled high in IDLE.
  - On entering OWNN: latch selN into the target register, set the last-grant flag to N, and assert the chosen cs_n low in the same cycle gntN rises.
  - selN changes are ignored while the bus is owned.
  - OWNN with reqN low and engine idle: go to IDLE next cycle; gntN and cs_n deassert together. The other requester can be granted no earlier than 1 cycle later, which guarantees at least 1 cycle of cs_n high between transactions.
  - OWNN with reqN low and engine busy: go to DRAIN. gntN stays high and the byte finishes normally. doneN pulses, then go to IDLE the following cycle.
  - Requests are never preempted.
- Byte engine (mode 0, MSB first):
  - A startN accepted only when gntN = 1 and the engine is idle. Otherwise it is ignored silently: no done pulse, no state change.
  - A start from the non-owning requester is always ignored.
  - On accept: load the shift register from txN and drive spi_mosi = bit 7. Then 8 times: CLKDIV cycles with SCK low, then CLKDIV cycles with SCK high.
  - MISO is sampled from the target's miso on each SCK rising edge. MOSI advances on each falling edge.
  - After the 8th high phase, SCK returns low. On that same cycle doneN pulses and rxN updates.
  - Total: done asserts 16*CLKDIV cycles after the start cycle.
  - rxN holds until that requester's next done.
  - spi_mosi returns to 1 when idle.
- Requester outputs are independent: requester 1's done/rx are never disturbed by requester 0's traffic.
- spi_busy = ~flash_cs_n | ~sd_cs_n, registered alongside the chip selects.
- Exactly one cs_n may be low at any time. The other target's clock activity is harmless because its cs_n is high.

Decomposition:
- Package zxuno_spi_pkg holds:
  - arbiter state encodings (IDLE/OWN0/OWN1/DRAIN);
  - TARGET_FLASH = 1'b0, TARGET_SD = 1'b1;
  - SPI_IDLE_MOSI = 1'b1.
- One sub-module, spi_byte_shifter (parameter CLKDIV). Ports: clk, rst, start, tx[7:0], miso, sck, mosi, busy, done, rx[7:0]. It contains the divider counter, the 3-bit bit counter and the shift register.
- The top level holds the arbiter FSM, the last-grant flag, the target latch, the MISO mux and the done/rx demux.

Test Plan:
- Single requester read: req1=1, sel1=1 → gnt1 at +1 cycle, sd_cs_n=0, flash_cs_n=1. Then start1 with tx1=8'hA5 and sd_miso returning 8'h3C. Required: spi_mosi shows 1,0,1,0,0,1,0,1 at the rising edges; done1 pulses 32 cycles after start (CLKDIV=2); rx1=8'h3C.
- Simultaneous request after reset: req0=req1=1 in the same cycle → gnt0 first. Drop req0 → after one idle cycle gnt1=1. On the next tie, requester 0 wins again only after requester 1 was granted last.
- Release mid-byte: req0 dropped 5 cycles after start0 → byte completes, done0 pulses, then gnt0=0 and flash_cs_n=1 the next cycle, with no truncated SCK pulses (exactly 8 rising edges).
- Ignored starts: start1 while gnt0=1, and start0 while the engine is busy → no done pulse, shift contents unchanged, SCK edge count still 8 per accepted byte.
- Reset mid-transfer: assert rst at bit 3 → same cycle: flash_cs_n=sd_cs_n=1, spi_clk=0, spi_mosi=1, gnt=0, no done. After release, a new req0 is granted in 1 cycle and a full byte transfers correctly.
- Back-to-back bytes: start0 issued in the cycle after done0 → accepted. SCK stays low for exactly CLKDIV cycles between the bytes; flash_cs_n stays low throughout.
